// File: rtl/uart_rx_cfg.sv
`default_nettype none
// uart_rx_cfg: configurable UART receiver with majority-vote bit decisions, framing/break
// detection and a 1-deep valid/ready output register. Parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial_in,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_S1    = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] CNT_S2    = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
  } state_t;
`endif

  state_t                 state;
  logic                   sync1;
  logic                   data;
  logic [CW-1:0]          count;
  logic [3:0]             bit_cnt;
  logic                   samp1;
  logic                   samp2;
  logic [DATA_BITS-1:0]   shreg;
  logic                   frame_err;
  logic                   par_err;
  logic                   first_stop;

  logic bit_val;
  logic at_end;
  logic in_bit;
  logic fe_next;
  logic brk_next;

  assign bit_val  = (samp1 & samp2) | (samp1 & data) | (samp2 & data);
  assign at_end   = (count == CNT_LAST);
`ifdef UART_RX_PARITY_EN
  assign in_bit   = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);
`else
  assign in_bit   = (state == S_DATA) || (state == S_STOP);
`endif
  assign fe_next  = frame_err | ~bit_val;
  // With one stop bit the first stop bit is the one being decided right now.
  assign brk_next = (shreg == '0) & ~((bit_cnt == 4'd0) ? bit_val : first_stop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      data  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      data  <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      count        <= '0;
      bit_cnt      <= '0;
      samp1        <= 1'b1;
      samp2        <= 1'b1;
      shreg        <= '0;
      frame_err    <= 1'b0;
      par_err      <= 1'b0;
      first_stop   <= 1'b1;
      o_byte       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;

      if (in_bit) begin
        if (count == CNT_S1) samp1 <= data;
        if (count == CNT_S2) samp2 <= data;
        count <= at_end ? '0 : count + 1'b1;
      end

      case (state)
        S_IDLE: begin
          count     <= '0;
          bit_cnt   <= '0;
          frame_err <= 1'b0;
          par_err   <= 1'b0;
          if (!data) state <= S_START;
        end
        S_START: begin
          if (count == CNT_HALF) begin
            count <= '0;
            state <= data ? S_IDLE : S_DATA;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DATA: begin
          if (at_end) begin
            // Shift in at the MSB so the first received bit ends up at position 0.
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (at_end) begin
            par_err <= ((^shreg) ^ bit_val) != ODD;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (at_end) begin
            if (bit_cnt == 4'd0) first_stop <= bit_val;
            frame_err <= fe_next;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= brk_next ? S_WAIT_HIGH : S_IDLE;
              if (o_valid && !i_ready) begin
                o_overrun <= 1'b1;
              end else begin
                o_byte       <= shreg;
                o_frame_err  <= fe_next;
                o_parity_err <= par_err;
                o_break      <= brk_next;
                o_valid      <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (data) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// tb_uart_rx_cfg: randomized and directed frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int C   = 20;
  localparam int H   = (C - 1) / 2;
  localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int N = DB + PB + SB;

  typedef struct packed {
    int unsigned   at;
    logic [DB-1:0] dat;
    logic          fe;
    logic          pe;
    logic          brk;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          serial_in;
  logic          i_ready;
  logic [DB-1:0] o_byte;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_parity_err;
  logic          o_break;
  logic          o_overrun;

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          valid_cycles = 0;
  rec_t        obs_q[$];
  rec_t        exp_q[$];
  int unsigned ovr_q[$];

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(ODD)) dut (
    .clock(clock), .reset_n(reset_n), .serial_in(serial_in), .i_ready(i_ready),
    .o_byte(o_byte), .o_valid(o_valid), .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err), .o_break(o_break), .o_overrun(o_overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Records every word the DUT delivers, and every overrun pulse, with the edge index.
  initial begin : monitor
    logic pv;
    rec_t r;
    pv = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (o_valid && (!pv || i_ready)) begin
        r.at = cyc; r.dat = o_byte; r.fe = o_frame_err; r.pe = o_parity_err; r.brk = o_break;
        obs_q.push_back(r);
      end
      if (o_valid) valid_cycles++;
      if (o_overrun) ovr_q.push_back(cyc);
      pv = o_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic string fmt(input rec_t r);
    return $sformatf("edge=%0d byte=%h fe=%b pe=%b brk=%b", r.at, r.dat, r.fe, r.pe, r.brk);
  endfunction

  // Drives one frame and pushes the model's expectation: word appears 3+H+N*C edges
  // after the first edge that samples the start bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic [SB-1:0] stops,
                            input bit end_low);
    rec_t e;
    e.at  = cyc + 1 + 3 + H + N * C;
    e.dat = d;
    e.fe  = (stops != {SB{1'b1}});
    e.pe  = (PB != 0) ? (((^d) ^ pbit) != ODD[0]) : 1'b0;
    e.brk = (d == '0) && !stops[0];
    exp_q.push_back(e);
    serial_in = 1'b0;
    tick(C);
    for (int i = 0; i < DB; i++) begin
      serial_in = d[i];
      tick(C);
    end
    if (PB != 0) begin
      serial_in = pbit;
      tick(C);
    end
    for (int i = 0; i < SB; i++) begin
      serial_in = stops[i];
      tick(C);
    end
    serial_in = end_low ? 1'b0 : 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    n_chk += 6;
    if (o_byte !== '0)        begin n_fail++; $display("FAIL reset_byte: got %h want 0", o_byte); end
    if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    if (o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", o_frame_err); end
    if (o_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", o_parity_err); end
    if (o_break !== 1'b0)     begin n_fail++; $display("FAIL reset_brk: got %b want 0", o_break); end
    if (o_overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_ovr: got %b want 0", o_overrun); end
    reset_n = 1'b1;
    tick(3 * C);
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_spurious: got %0d words want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    valid_cycles = 0;
    send_frame(DB'(8'hA5), 1'b0, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk += 2;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d words want 1", obs_q.size()); end
    if (valid_cycles != 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d cycles want 1", valid_cycles); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_word: got %s want %s", fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    serial_in = 1'b0;
    tick(2);
    serial_in = 1'b1;
    tick(3 * C);
    n_chk++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_word: got %0d words want 0", obs_q.size()); end
    obs_q.delete();
    send_frame(DB'(8'h96), 1'b1, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL glitch_after_count: got %0d want 1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_after_word: got %s want %s", fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_break();
    i_ready = 1'b1;
    send_frame(DB'(8'h3C), 1'b0, {SB{1'b0}}, 1'b0);
    tick(2 * C);
    send_frame('0, 1'b0, {SB{1'b0}}, 1'b1);
    tick(4 * C);                       // line held low long after the break
    serial_in = 1'b1;
    tick(C);
    send_frame(DB'(8'h81), 1'b0, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk += 3;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL break_count: got %0d want 3", obs_q.size()); end
    if (exp_q[0].fe !== 1'b1 || exp_q[0].brk !== 1'b0) begin n_fail++; $display("FAIL break_model_fe: got fe=%b brk=%b want 1 0", exp_q[0].fe, exp_q[0].brk); end
    if (obs_q.size() > 1 && (obs_q[1].brk !== 1'b1 || obs_q[1].fe !== 1'b1)) begin
      n_fail++; $display("FAIL break_flags: got brk=%b fe=%b want 1 1", obs_q[1].brk, obs_q[1].fe);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL break_word%0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    i_ready = 1'b1;
    send_frame(DB'(8'h41), 1'b0, {SB{1'b1}}, 1'b0);
    tick(C);
    send_frame(DB'(8'h41), 1'b1, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL parity_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_chk += 2;
      if (obs_q[0].pe !== 1'b0) begin n_fail++; $display("FAIL parity_ok: got pe=%b want 0", obs_q[0].pe); end
      if (obs_q[1].pe !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got pe=%b want 1", obs_q[1].pe); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL parity_word%0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  task automatic test_random();
    logic [DB-1:0] d;
    logic [SB-1:0] st;
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d = ($urandom_range(0, 3) == 0) ? '0 : DB'($urandom);
      for (int b = 0; b < SB; b++) st[b] = ($urandom_range(0, 3) != 0);
      send_frame(d, 1'($urandom), st, 1'b0);
      // A low final stop bit needs a full idle bit before the next start to keep timing exact.
      tick(st[SB-1] ? $urandom_range(1, C) : C + $urandom_range(0, C));
    end
    tick(4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word%0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_frame(DB'($urandom), 1'($urandom), {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk++;
    if (obs_q.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun();
    i_ready = 1'b0;
    ovr_q.delete();
    send_frame(DB'(8'h11), 1'b0, {SB{1'b1}}, 1'b0);
    tick(C);
    send_frame(DB'(8'h22), 1'b0, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk += 4;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL ovr_word: got %s want %s", fmt(obs_q[0]), fmt(exp_q[0])); end
    if (ovr_q.size() != 1 || ovr_q[0] != exp_q[1].at) begin
      n_fail++; $display("FAIL ovr_pulse: got %0d pulses first at %0d want 1 at %0d", ovr_q.size(), (ovr_q.size() > 0) ? ovr_q[0] : 0, exp_q[1].at);
    end
    if (o_valid !== 1'b1 || o_byte !== DB'(8'h11)) begin n_fail++; $display("FAIL ovr_hold: got valid=%b byte=%h want 1 %h", o_valid, o_byte, DB'(8'h11)); end
    i_ready = 1'b1;
    tick(1);
    n_chk++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_release: got valid=%b want 0", o_valid); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] d;
    d = DB'(8'hC3);
    serial_in = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) begin
      serial_in = d[i];
      tick(C);
    end
    serial_in = d[3];
    tick(C / 2);
    reset_n = 1'b0;
    serial_in = 1'b1;
    tick(3);
    n_chk += 2;
    if (o_byte !== '0)    begin n_fail++; $display("FAIL midrst_byte: got %h want 0", o_byte); end
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    reset_n = 1'b1;
    tick(2 * C);
    obs_q.delete();
    send_frame(DB'(8'h5A), 1'b0, {SB{1'b1}}, 1'b0);
    tick(4);
    n_chk++;
    if (obs_q.size() != 1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_word: got %s want %s", fmt(obs_q[i]), fmt(exp_q[i])); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    serial_in = 1'b1;
    i_ready   = 1'b1;
    reset_n   = 1'b0;
    tick(1);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
